// File: rtl/encrypt_pipe_pkg.sv
// Shared types, constants and modular helpers for the lane-rotation pipeline.
// Digit classification exists only when ROT_DIGITS_EN is defined.
package encrypt_pipe_pkg;

    typedef logic [7:0] char_t;
    typedef logic [4:0] shift_t;

    typedef enum logic [1:0] {
        CC_OTHER = 2'd0,
        CC_UPPER = 2'd1,
        CC_LOWER = 2'd2,
        CC_DIGIT = 2'd3
    } char_class_e;

    localparam shift_t ALPHA_LEN = 5'd26;
    localparam shift_t DIGIT_LEN = 5'd10;
    localparam char_t  ASC_UPPER = 8'd65;
    localparam char_t  ASC_LOWER = 8'd97;
    localparam char_t  ASC_ZERO  = 8'd48;

    // Both operands are already below 26, so the sum needs at most one correction.
    function automatic shift_t mod26_add(input shift_t a, input shift_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, ALPHA_LEN}) begin
            s = s - {1'b0, ALPHA_LEN};
        end else begin
            s = s;
        end
        return s[4:0];
    endfunction

    function automatic shift_t mod26_reduce(input shift_t v);
        if (v >= ALPHA_LEN) begin
            return v - ALPHA_LEN;
        end else begin
            return v;
        end
    endfunction

    function automatic char_class_e classify(input char_t c);
        if ((c >= ASC_UPPER) && (c < ASC_UPPER + {3'b000, ALPHA_LEN})) begin
            return CC_UPPER;
        end else if ((c >= ASC_LOWER) && (c < ASC_LOWER + {3'b000, ALPHA_LEN})) begin
            return CC_LOWER;
`ifdef ROT_DIGITS_EN
        end else if ((c >= ASC_ZERO) && (c < ASC_ZERO + {3'b000, DIGIT_LEN})) begin
            return CC_DIGIT;
`endif
        end else begin
            return CC_OTHER;
        end
    endfunction

endpackage

// File: rtl/encrypt_rot_lane.sv
// Combinational single-character rotator: letters by k mod 26, and with
// ROT_DIGITS_EN defined, digits by k mod 10. Everything else passes through.
module encrypt_rot_lane
    import encrypt_pipe_pkg::*;
(
    input  char_t       i_char,
    input  char_class_e i_class,
    input  shift_t      i_k,
    input  logic        i_dir,
    output char_t       o_char
);

    shift_t     w_k_alpha;
    char_t      w_base;
    shift_t     w_off;
    logic [5:0] w_sum;
`ifdef ROT_DIGITS_EN
    shift_t     w_kd;
    logic [3:0] w_doff;
    shift_t     w_dsum;
`endif

    // Rotate one character; decrypt is rotation by the additive inverse
    always_comb begin
        if (i_dir && (i_k != 5'd0)) begin
            w_k_alpha = ALPHA_LEN - i_k;
        end else begin
            w_k_alpha = i_k;
        end
        if (i_class == CC_UPPER) begin
            w_base = ASC_UPPER;
        end else begin
            w_base = ASC_LOWER;
        end
        w_off = 5'(i_char - w_base);
        w_sum = {1'b0, w_off} + {1'b0, w_k_alpha};
        if (w_sum >= {1'b0, ALPHA_LEN}) begin
            w_sum = w_sum - {1'b0, ALPHA_LEN};
        end else begin
            w_sum = w_sum;
        end
`ifdef ROT_DIGITS_EN
        // k < 26, so two conditional subtracts give k mod 10
        w_kd = i_k;
        if (w_kd >= DIGIT_LEN) begin
            w_kd = w_kd - DIGIT_LEN;
        end else begin
            w_kd = w_kd;
        end
        if (w_kd >= DIGIT_LEN) begin
            w_kd = w_kd - DIGIT_LEN;
        end else begin
            w_kd = w_kd;
        end
        if (i_dir && (w_kd != 5'd0)) begin
            w_kd = DIGIT_LEN - w_kd;
        end else begin
            w_kd = w_kd;
        end
        w_doff = 4'(i_char - ASC_ZERO);
        w_dsum = {1'b0, w_doff} + w_kd;
        if (w_dsum >= DIGIT_LEN) begin
            w_dsum = w_dsum - DIGIT_LEN;
        end else begin
            w_dsum = w_dsum;
        end
`endif
        case (i_class)
            CC_UPPER, CC_LOWER: o_char = w_base + {2'b00, w_sum};
`ifdef ROT_DIGITS_EN
            CC_DIGIT:           o_char = ASC_ZERO + {3'b000, w_dsum};
`endif
            default:            o_char = i_char;
        endcase
    end

endmodule

// File: rtl/encrypt_pipe_rotate_lanes.sv
// Two-stage valid/ready pipeline rotating LANES ASCII characters per beat,
// fixed or rolling key. Digit rotation is enabled by defining ROT_DIGITS_EN.
module encrypt_pipe_rotate_lanes
    import encrypt_pipe_pkg::*;
#(
    parameter int LANES = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [4:0]         cfg_shift,
    input  logic [4:0]         cfg_step,
    input  logic               cfg_dir,
    input  logic               cfg_roll,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_last,
    output logic               busy
);

    localparam int W = 8 * LANES;

    shift_t      r_shift;
    shift_t      r_step;
    shift_t      r_base;
    logic        r_dir;
    logic        r_roll;

    logic        r_s1_valid;
    logic        r_s1_last;
    logic [W-1:0] r_s1_data;
    shift_t      r_s1_k     [LANES];
    char_class_e r_s1_class [LANES];

    logic        r_s2_valid;
    logic        r_s2_last;
    logic [W-1:0] r_s2_data;

    logic        w_busy;
    logic        w_s2_free;
    logic        w_s1_adv;
    logic        w_accept;
    logic        w_cfg_take;
    shift_t      w_roll_k [LANES];
    shift_t      w_base_next;
    logic [W-1:0] w_rot;

    assign w_busy     = r_s1_valid | r_s2_valid;
    assign w_s2_free  = ~r_s2_valid | out_ready;
    assign w_s1_adv   = r_s1_valid & w_s2_free;
    assign in_ready   = ~rst & ~cfg_load & (~r_s1_valid | w_s2_free);
    assign w_accept   = in_valid & in_ready;
    assign w_cfg_take = cfg_load & ~w_busy;

    assign out_valid  = r_s2_valid;
    assign out_data   = r_s2_data;
    assign out_last   = r_s2_last;
    assign busy       = w_busy;

    // Rolling key per lane: base + i*step (mod 26), plus the base for the next beat
    always_comb begin
        shift_t v_acc;
        v_acc = r_base;
        for (int i = 0; i < LANES; i++) begin
            w_roll_k[i] = v_acc;
            v_acc       = mod26_add(v_acc, r_step);
        end
        w_base_next = v_acc;
    end

    // Configuration and rolling base; load is honoured only with an empty pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= 5'd0;
            r_step  <= 5'd0;
            r_base  <= 5'd0;
            r_dir   <= 1'b0;
            r_roll  <= 1'b0;
        end else if (w_cfg_take) begin
            r_shift <= mod26_reduce(cfg_shift);
            r_step  <= mod26_reduce(cfg_step);
            r_base  <= mod26_reduce(cfg_shift);
            r_dir   <= cfg_dir;
            r_roll  <= cfg_roll;
        end else if (w_accept) begin
            r_base  <= in_last ? r_shift : w_base_next;
        end
    end

    // Stage 1: beat, per-lane shift and character class
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_data  <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_k[i]     <= 5'd0;
                r_s1_class[i] <= CC_OTHER;
            end
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= in_last;
            r_s1_data  <= in_data;
            for (int i = 0; i < LANES; i++) begin
                r_s1_k[i]     <= r_roll ? w_roll_k[i] : r_shift;
                r_s1_class[i] <= classify(in_data[8*i +: 8]);
            end
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        encrypt_rot_lane u_lane (
            .i_char  (r_s1_data[8*g +: 8]),
            .i_class (r_s1_class[g]),
            .i_k     (r_s1_k[g]),
            .i_dir   (r_dir),
            .o_char  (w_rot[8*g +: 8])
        );
    end

    // Stage 2: rotated output, held while the sink stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_last  <= r_s1_last;
            r_s2_data  <= w_rot;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encrypt_pipe_rotate_lanes.sv
// Self-checking bench for encrypt_pipe_rotate_lanes (LANES=4) with a
// character-level reference model and directed plus randomized scenarios.
module tb_encrypt_pipe_rotate_lanes;

    localparam int LANES = 4;
    localparam int W     = 8 * LANES;

    logic         clk = 1'b0;
    logic         rst, cfg_load, cfg_dir, cfg_roll;
    logic [4:0]   cfg_shift, cfg_step;
    logic         in_valid, in_ready, in_last;
    logic         out_valid, out_ready, out_last, busy;
    logic [W-1:0] in_data, out_data;

    int n_vec = 0;
    int n_err = 0;
    int m_shift, m_step, m_dir, m_roll, m_base;
    logic [W:0] exp_q[$];
    logic [W:0] got_q[$];
    logic acc_flag;

    encrypt_pipe_rotate_lanes #(.LANES(LANES)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_shift(cfg_shift),
        .cfg_step(cfg_step), .cfg_dir(cfg_dir), .cfg_roll(cfg_roll),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pk(input string s);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [W-1:0] model_rot(input logic [W-1:0] d);
        logic [W-1:0] r;
        int k, ka, kd, c;
        for (int i = 0; i < LANES; i++) begin
            c  = int'(d[8*i +: 8]);
            k  = m_roll ? (m_base + i * m_step) % 26 : m_shift;
            ka = m_dir ? (26 - k) % 26 : k;
            kd = m_dir ? (10 - k % 10) % 10 : k % 10;
            if (c >= 65 && c <= 90)       c = 65 + (c - 65 + ka) % 26;
            else if (c >= 97 && c <= 122) c = 97 + (c - 97 + ka) % 26;
`ifdef ROT_DIGITS_EN
            else if (c >= 48 && c <= 57)  c = 48 + (c - 48 + kd) % 10;
`endif
            r[8*i +: 8] = 8'(c);
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        acc_flag = in_valid && in_ready;
        if (acc_flag) begin
            exp_q.push_back({in_last, model_rot(in_data)});
            if (in_last) m_base = m_shift;
            else         m_base = (m_base + LANES * m_step) % 26;
        end
        if (out_valid && out_ready) got_q.push_back({out_last, out_data});
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int sh, input int st, input logic dir, input logic roll);
        int t;
        t = 0;
        while (busy && t < 50) begin tick(); t++; end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL load_drain busy=%b want 0", busy); end
        cfg_shift = 5'(sh); cfg_step = 5'(st); cfg_dir = dir; cfg_roll = roll;
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
        m_shift = sh % 26; m_step = st % 26; m_dir = dir; m_roll = roll; m_base = m_shift;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        int t;
        in_valid = 1'b1; in_data = d; in_last = last;
        t = 0;
        tick();
        while (!acc_flag && t < 50) begin tick(); t++; end
        in_valid = 1'b0;
        n_vec++;
        if (acc_flag !== 1'b1) begin n_err++; $display("FAIL send_accept got=0 want 1"); end
    endtask

    task automatic collect(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 200) begin tick(); t++; end
        n_vec++;
        if (got_q.size() != n) begin n_err++; $display("FAIL collect_count got=%0d want %0d", got_q.size(), n); end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_load = 1'b0; cfg_shift = 5'd0; cfg_step = 5'd0; cfg_dir = 1'b0;
        cfg_roll = 1'b0; in_valid = 1'b1; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b want 0", out_valid); end
        n_vec++; if (out_data !== '0)    begin n_err++; $display("FAIL rst_out_data got=%h want 0", out_data); end
        n_vec++; if (out_last !== 1'b0)  begin n_err++; $display("FAIL rst_out_last got=%b want 0", out_last); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy got=%b want 0", busy); end
        n_vec++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL rst_in_ready got=%b want 0", in_ready); end
        in_valid = 1'b0; rst = 1'b0;
        m_shift = 0; m_step = 0; m_dir = 0; m_roll = 0; m_base = 0;
        tick();
    endtask

    task automatic test_fixed();
        load(3, 0, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = pk("abcZ"); in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t1_latency out_valid=%b want 0", out_valid); end
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid got=%b want 1", out_valid); end
        n_vec++; if (out_data !== pk("defC")) begin n_err++; $display("FAIL t1_enc got=%h want %h", out_data, pk("defC")); end
        n_vec++; if (out_last !== 1'b1) begin n_err++; $display("FAIL t1_last got=%b want 1", out_last); end
        load(3, 0, 1'b1, 1'b0);
        send(pk("defC"), 1'b0);
        tick();
        n_vec++; if (out_data !== pk("abcZ")) begin n_err++; $display("FAIL t1_dec got=%h want %h", out_data, pk("abcZ")); end
    endtask

    task automatic test_roll();
        logic [W:0] want [3];
        want[0] = {1'b0, pk("bcde")}; want[1] = {1'b1, pk("fghi")}; want[2] = {1'b0, pk("bcde")};
        load(1, 1, 1'b0, 1'b1);
        for (int b = 0; b < 3; b++) send(pk("aaaa"), b == 1);
        collect(3);
        if (got_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (got_q[i] !== want[i]) begin n_err++; $display("FAIL t2_roll[%0d] got=%h want %h", i, got_q[i], want[i]); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] want;
`ifdef ROT_DIGITS_EN
        want = pk("y!Z4");
`else
        want = pk("y!Z9");
`endif
        load(25, 0, 1'b0, 1'b0);
        send(pk("z!A9"), 1'b0);
        collect(1);
        if (got_q.size() == 1) begin
            n_vec++;
            if (got_q[0][W-1:0] !== want) begin n_err++; $display("FAIL t3_wrap got=%h want %h", got_q[0][W-1:0], want); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] b [3];
        logic [W-1:0] hold;
        int idx, t;
        for (int i = 0; i < 3; i++) b[i] = pk("aaaa") + W'($urandom_range(0, 25)) * 32'h01010101;
        load(5, 0, 1'b0, 1'b0);
        out_ready = 1'b0; idx = 0; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = b[idx]; in_last = (idx == 2);
            tick();
            if (acc_flag) idx++;
        end
        n_vec++; if (idx != 2) begin n_err++; $display("FAIL t4_taken got=%0d want 2", idx); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t4_in_ready got=%b want 0", in_ready); end
        hold = out_data;
        n_vec++; if (hold !== exp_q[0][W-1:0]) begin n_err++; $display("FAIL t4_head got=%h want %h", hold, exp_q[0][W-1:0]); end
        tick(); tick();
        n_vec++; if (out_data !== hold) begin n_err++; $display("FAIL t4_stable got=%h want %h", out_data, hold); end
        out_ready = 1'b1; t = 0;
        while (idx < 3 && t < 20) begin
            in_data = b[idx]; in_last = (idx == 2);
            tick();
            if (acc_flag) idx++;
            t++;
        end
        in_valid = 1'b0;
        collect(3);
        if (got_q.size() == 3 && exp_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL t4_order[%0d] got=%h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_cfg_busy();
        load(2, 0, 1'b0, 1'b0);
        out_ready = 1'b0;
        send(pk("abcd"), 1'b0);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t5_busy got=%b want 1", busy); end
        cfg_shift = 5'd7; cfg_load = 1'b1;
        in_valid = 1'b1; in_data = pk("wxyz"); in_last = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t5_in_ready got=%b want 0", in_ready); end
        tick();
        cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_vec++; if (acc_flag !== 1'b0) begin n_err++; $display("FAIL t5_no_accept got=%b want 0", acc_flag); end
        collect(1);
        send(pk("abcd"), 1'b1);
        collect(2);
        if (got_q.size() == 2) begin
            n_vec++; if (got_q[0][W-1:0] !== pk("cdef")) begin n_err++; $display("FAIL t5_old_shift0 got=%h want %h", got_q[0][W-1:0], pk("cdef")); end
            n_vec++; if (got_q[1][W-1:0] !== pk("cdef")) begin n_err++; $display("FAIL t5_old_shift1 got=%h want %h", got_q[1][W-1:0], pk("cdef")); end
        end
    endtask

    task automatic test_rst_mid();
        load(4, 0, 1'b0, 1'b0);
        out_ready = 1'b0;
        send(pk("abcd"), 1'b0);
        send(pk("efgh"), 1'b0);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t6_inflight got=%b want 1", out_valid); end
        rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t6_out_valid got=%b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL t6_busy got=%b want 0", busy); end
        tick();
        rst = 1'b0;
        m_shift = 0; m_step = 0; m_dir = 0; m_roll = 0; m_base = 0;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b1;
        send(pk("ab1!"), 1'b1);
        collect(1);
        if (got_q.size() == 1) begin
            n_vec++; if (got_q[0][W-1:0] !== pk("ab1!")) begin n_err++; $display("FAIL t6_pass got=%h want %h", got_q[0][W-1:0], pk("ab1!")); end
        end
    endtask

    task automatic test_random();
        int sent, t, r;
        for (int round = 0; round < 4; round++) begin
            load($urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            sent = 0; t = 0;
            while (sent < 40 && t < 400) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                in_last   = ($urandom_range(0, 4) == 0);
                for (int i = 0; i < LANES; i++) begin
                    r = $urandom_range(0, 3);
                    case (r)
                        0:       in_data[8*i +: 8] = 8'(65 + $urandom_range(0, 25));
                        1:       in_data[8*i +: 8] = 8'(97 + $urandom_range(0, 25));
                        2:       in_data[8*i +: 8] = 8'(48 + $urandom_range(0, 9));
                        default: in_data[8*i +: 8] = 8'($urandom_range(0, 255));
                    endcase
                end
                tick();
                if (acc_flag) sent++;
                t++;
            end
            in_valid = 1'b0; out_ready = 1'b1;
            collect(sent);
            if (got_q.size() == sent && exp_q.size() == sent) begin
                for (int i = 0; i < sent; i++) begin
                    n_vec++;
                    if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d[%0d] got=%h want %h", round, i, got_q[i], exp_q[i]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_roll();
        test_wrap();
        test_backpressure();
        test_cfg_busy();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
